// File: rtl/ps_setpoint_coef_scheduler_pkg.sv
// Shared types and sizing for the psSetpointCalc coefficient write scheduler.
// Table encodings, the staged-entry layout and the scheduler state encoding live here.
package ps_setpoint_coef_scheduler_pkg;

    localparam int RESULT_COUNT       = 24;
    localparam int RESULT_COUNT_WIDTH = (RESULT_COUNT > 1) ? $clog2(RESULT_COUNT) : 1;
    localparam int DBUS_WIDTH         = 32;
    localparam int FIFO_DEPTH         = 16;
    localparam int FIFO_AW            = $clog2(FIFO_DEPTH);
    localparam int PENDING_WIDTH      = FIFO_AW + 1;
    localparam int BUSY_CYCLES        = RESULT_COUNT + 8;
    localparam int BUSY_CNT_WIDTH     = $clog2(BUSY_CYCLES);
    localparam int DEFER_WIDTH        = 16;

    typedef enum logic [1:0] {
        TABLE_GAIN     = 2'd0,
        TABLE_FFBCLIP  = 2'd1,
        TABLE_PSOFFSET = 2'd2,
        TABLE_PSCLIP   = 2'd3
    } coef_table_e;

    typedef struct packed {
        coef_table_e                   tbl;
        logic [RESULT_COUNT_WIDTH-1:0] address;
        logic [DBUS_WIDTH-1:0]         data;
    } coef_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/ps_setpoint_coef_scheduler_coef_write_fifo.sv
// Staging FIFO with three pointers: head (next to apply), commit boundary and tail.
// A commit after a dropped write rewinds the tail to the boundary, discarding that whole batch.
module coef_write_fifo
    import ps_setpoint_coef_scheduler_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  coef_entry_t              push_entry_i,
    input  logic                     commit_i,
    input  logic                     pop_i,
    output coef_entry_t              pop_entry_o,
    output logic [PENDING_WIDTH-1:0] pending_count_o,
    output logic [PENDING_WIDTH-1:0] committed_count_o,
    output logic                     drop_o
);

    coef_entry_t              mem_q [FIFO_DEPTH];
    logic [PENDING_WIDTH-1:0] head_q, head_d;
    logic [PENDING_WIDTH-1:0] commit_q, commit_d;
    logic [PENDING_WIDTH-1:0] tail_q, tail_d;
    logic [PENDING_WIDTH-1:0] tail_push;
    logic                     rewind_q, rewind_d;
    logic                     full;
    logic                     accept;

    assign pending_count_o   = tail_q - head_q;
    assign committed_count_o = commit_q - head_q;
    assign full              = (pending_count_o == PENDING_WIDTH'(FIFO_DEPTH));
    assign accept            = push_i & ~full;
    assign drop_o            = push_i & full;
    assign tail_push         = tail_q + PENDING_WIDTH'(accept);
    assign pop_entry_o       = mem_q[head_q[FIFO_AW-1:0]];

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        head_d   = head_q + PENDING_WIDTH'(pop_i);
        tail_d   = tail_push;
        commit_d = commit_q;
        rewind_d = rewind_q | drop_o;
        if (commit_i) begin
            rewind_d = 1'b0;
            if (rewind_q || drop_o) begin
                tail_d = commit_q;
            end else begin
                commit_d = tail_push;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q   <= '0;
            commit_q <= '0;
            tail_q   <= '0;
            rewind_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            commit_q <= commit_d;
            tail_q   <= tail_d;
            rewind_q <= rewind_d;
        end
    end

    // NOTE: the storage array is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[tail_q[FIFO_AW-1:0]] <= push_entry_i;
        end
    end

endmodule

// File: rtl/ps_setpoint_coef_scheduler.sv
// Applies committed coefficient batches to psSetpointCalc tables only between frames,
// owning the frame toggle so a frame arriving mid-batch is held until the batch completes.
module ps_setpoint_coef_scheduler
    import ps_setpoint_coef_scheduler_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cpuWriteStrobe_i,
    input  logic [1:0]                    cpuTable_i,
    input  logic [RESULT_COUNT_WIDTH-1:0] cpuAddress_i,
    input  logic [DBUS_WIDTH-1:0]         cpuData_i,
    input  logic                          cpuCommitStrobe_i,
    input  logic                          cpuClearStatus_i,
    input  logic                          dinToggleIn_i,
    output logic                          dinToggleOut_o,
    output logic                          gainWriteStrobe_o,
    output logic                          ffbClipWriteStrobe_o,
    output logic                          psOffsetWriteStrobe_o,
    output logic                          psClipWriteStrobe_o,
    output logic [RESULT_COUNT_WIDTH-1:0] writeAddress_o,
    output logic [DBUS_WIDTH-1:0]         writeData_o,
    output logic [PENDING_WIDTH-1:0]      pendingCount_o,
    output logic                          overflow_o,
    output logic [DEFER_WIDTH-1:0]        deferredFrames_o,
    output logic                          busy_o
);

    state_e                        state_q, state_d;
    logic                          tracker_q;
    logic                          toggle_out_q, toggle_out_d;
    logic                          deferred_q, deferred_d;
    logic [BUSY_CNT_WIDTH-1:0]     busy_cnt_q, busy_cnt_d;
    logic [3:0]                    strobe_q, strobe_d;
    logic [RESULT_COUNT_WIDTH-1:0] waddr_q, waddr_d;
    logic [DBUS_WIDTH-1:0]         wdata_q, wdata_d;
    logic                          overflow_q;
    logic [DEFER_WIDTH-1:0]        defer_cnt_q;
    logic                          toggle_edge, pop, defer_event, drop;
    coef_entry_t                   push_entry, head_entry;
    logic [PENDING_WIDTH-1:0]      committed_count;

    assign push_entry  = '{tbl: coef_table_e'(cpuTable_i), address: cpuAddress_i, data: cpuData_i};
    assign toggle_edge = dinToggleIn_i != tracker_q;

    coef_write_fifo u_fifo (
        .clk               (clk),
        .rst               (rst),
        .push_i            (cpuWriteStrobe_i),
        .push_entry_i      (push_entry),
        .commit_i          (cpuCommitStrobe_i),
        .pop_i             (pop),
        .pop_entry_o       (head_entry),
        .pending_count_o   (pendingCount_o),
        .committed_count_o (committed_count),
        .drop_o            (drop)
    );

    always_comb begin
        state_d      = state_q;
        toggle_out_d = toggle_out_q;
        deferred_d   = deferred_q;
        busy_cnt_d   = busy_cnt_q;
        strobe_d     = '0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        pop          = 1'b0;
        defer_event  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (toggle_edge) begin
                    toggle_out_d = dinToggleIn_i;
                    busy_cnt_d   = BUSY_CNT_WIDTH'(BUSY_CYCLES - 1);
                    state_d      = ST_BUSY;
                end else if (committed_count != '0) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_BUSY: begin
                if (toggle_edge) begin
                    toggle_out_d = dinToggleIn_i;
                    busy_cnt_d   = BUSY_CNT_WIDTH'(BUSY_CYCLES - 1);
                end else if (busy_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    busy_cnt_d = busy_cnt_q - 1'b1;
                end
            end
            ST_DRAIN: begin
                if (toggle_edge && !deferred_q) begin
                    deferred_d  = 1'b1;
                    defer_event = 1'b1;
                end
                if (committed_count != '0) begin
                    pop                     = 1'b1;
                    strobe_d[head_entry.tbl] = 1'b1;
                    waddr_d                 = head_entry.address;
                    wdata_d                 = head_entry.data;
                end else if (deferred_q || toggle_edge) begin
                    // Last strobe is on the table now; release the held frame.
                    deferred_d   = 1'b0;
                    toggle_out_d = dinToggleIn_i;
                    busy_cnt_d   = BUSY_CNT_WIDTH'(BUSY_CYCLES - 1);
                    state_d      = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tracker_q    <= 1'b0;
            toggle_out_q <= 1'b0;
            deferred_q   <= 1'b0;
            busy_cnt_q   <= '0;
            strobe_q     <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            overflow_q   <= 1'b0;
            defer_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            tracker_q    <= dinToggleIn_i;
            toggle_out_q <= toggle_out_d;
            deferred_q   <= deferred_d;
            busy_cnt_q   <= busy_cnt_d;
            strobe_q     <= strobe_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (cpuClearStatus_i) begin
                overflow_q <= 1'b0;
            end
            if (defer_event) begin
                if (defer_cnt_q != '1) begin
                    defer_cnt_q <= defer_cnt_q + 16'd1;
                end
            end else if (cpuClearStatus_i) begin
                defer_cnt_q <= '0;
            end
        end
    end

    assign dinToggleOut_o        = toggle_out_q;
    assign gainWriteStrobe_o     = strobe_q[TABLE_GAIN];
    assign ffbClipWriteStrobe_o  = strobe_q[TABLE_FFBCLIP];
    assign psOffsetWriteStrobe_o = strobe_q[TABLE_PSOFFSET];
    assign psClipWriteStrobe_o   = strobe_q[TABLE_PSCLIP];
    assign writeAddress_o        = waddr_q;
    assign writeData_o           = wdata_q;
    assign overflow_o            = overflow_q;
    assign deferredFrames_o      = defer_cnt_q;
    assign busy_o                = state_q != ST_IDLE;

endmodule

// File: tb/tb_ps_setpoint_coef_scheduler.sv
// Scoreboard bench: stimulus pushes expected table writes, a negedge monitor pops and compares
// them as strobes appear, and also enforces the quiet window after every forwarded frame toggle.
module tb_ps_setpoint_coef_scheduler;
    import ps_setpoint_coef_scheduler_pkg::*;

    typedef struct {
        logic [1:0]  tbl;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_we = 1'b0, cpu_commit = 1'b0, cpu_clear = 1'b0, din = 1'b0;
    logic [1:0]  cpu_table = '0;
    logic [4:0]  cpu_addr = '0;
    logic [31:0] cpu_data = '0;
    logic        dout, st_gain, st_ffb, st_off, st_clip, busy, overflow;
    logic [4:0]  waddr, pending;
    logic [31:0] wdata;
    logic [15:0] deferred;

    ps_setpoint_coef_scheduler dut (
        .clk(clk), .rst(rst),
        .cpuWriteStrobe_i(cpu_we), .cpuTable_i(cpu_table), .cpuAddress_i(cpu_addr),
        .cpuData_i(cpu_data), .cpuCommitStrobe_i(cpu_commit), .cpuClearStatus_i(cpu_clear),
        .dinToggleIn_i(din), .dinToggleOut_o(dout),
        .gainWriteStrobe_o(st_gain), .ffbClipWriteStrobe_o(st_ffb),
        .psOffsetWriteStrobe_o(st_off), .psClipWriteStrobe_o(st_clip),
        .writeAddress_o(waddr), .writeData_o(wdata), .pendingCount_o(pending),
        .overflow_o(overflow), .deferredFrames_o(deferred), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int  cyc = 0;
    int  n_checks = 0, n_pass = 0;
    int  strobe_seen = 0, last_tog_cyc = 0;
    bit  toggle_seen = 1'b0;
    logic prev_out = 1'b0;
    int  strobe_cyc_log[$];
    wr_t unc_q[$], exp_q[$];
    bit  drop_flag = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: toggle watcher first, so a strobe in the same cycle as a toggle shows a zero gap.
    always @(negedge clk) begin
        logic [3:0] s;
        wr_t e;
        if (!rst) begin
            if (dout !== prev_out) begin
                last_tog_cyc = cyc;
                toggle_seen  = 1'b1;
            end
            prev_out = dout;
            s = {st_clip, st_off, st_ffb, st_gain};
            if (s != 4'b0) begin
                strobe_seen++;
                strobe_cyc_log.push_back(cyc);
                check("strobe_onehot", $countones(s), 1);
                if (toggle_seen) check("quiet_after_toggle", (cyc - last_tog_cyc) >= BUSY_CYCLES, 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", s, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_table", s, 4'b0001 << e.tbl);
                    check("strobe_addr", waddr, e.addr);
                    check("strobe_data", wdata, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: writes queue up uncommitted; a commit either releases them in order or,
    // if any write of the batch was refused for lack of room, throws the whole batch away.
    task automatic drive(input bit we, input int tbl, input int addr, input logic [31:0] d,
                         input bit cm, input bit clr);
        wr_t w;
        cpu_we = we; cpu_table = 2'(tbl); cpu_addr = 5'(addr); cpu_data = d;
        cpu_commit = cm; cpu_clear = clr;
        if (we) begin
            if (unc_q.size() + exp_q.size() >= FIFO_DEPTH) drop_flag = 1'b1;
            else begin
                w.tbl = 2'(tbl); w.addr = 5'(addr); w.data = d;
                unc_q.push_back(w);
            end
        end
        if (cm) begin
            if (!drop_flag) foreach (unc_q[i]) exp_q.push_back(unc_q[i]);
            unc_q.delete();
            drop_flag = 1'b0;
        end
        tick();
        cpu_we = 1'b0; cpu_commit = 1'b0; cpu_clear = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_quiet(input int max);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < max) begin
            tick();
            n++;
            if (!busy && exp_q.size() == 0) quiet++;
            else quiet = 0;
        end
        check("settle_in_time", quiet >= 3, 1);
    endtask

    task automatic wait_strobes(input int target, input int max);
        int n = 0;
        while (strobe_seen < target && n < max) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("strobe_in_time", strobe_seen >= target, 1);
    endtask

    int base;

    initial begin
        idle(4);
        rst = 1'b0;
        #0;
        check("rst_strobes", {st_clip, st_off, st_ffb, st_gain}, 0);
        check("rst_addr", waddr, 0);
        check("rst_data", wdata, 0);
        check("rst_toggle", dout, 0);
        check("rst_overflow", overflow, 0);
        check("rst_deferred", deferred, 0);
        check("rst_pending", pending, 0);
        check("rst_busy", busy, 0);

        // 1: three writes, one commit, no frames.
        drive(1, 0, 0, 32'h0010_0000, 0, 0);
        drive(1, 1, 5, 32'h0000_1000, 0, 0);
        drive(1, 3, 23, 32'h07FF_FFFF, 0, 0);
        check("t1_pending_staged", pending, 3);
        base = strobe_seen;
        drive(0, 0, 0, 0, 1, 0);
        wait_quiet(100);
        check("t1_strobe_count", strobe_seen - base, 3);
        check("t1_back_to_back", strobe_cyc_log[base+2] - strobe_cyc_log[base], 2);
        check("t1_pending_drained", pending, 0);

        // 2: frame first, batch committed three cycles later waits out the busy window.
        base = strobe_seen;
        din = ~din;
        drive(0, 0, 0, 0, 0, 0);
        check("t2_toggle_forwarded", dout, din);
        drive(1, 2, 7, 32'hA5A5_0001, 0, 0);
        drive(1, 0, 1, 32'h0000_0123, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        wait_quiet(200);
        check("t2_strobe_count", strobe_seen - base, 2);

        // 3: frame arrives on the 2nd strobe of an 8-entry batch and is held to the end.
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) drive(1, i % 4, i * 3, 32'h1000 + i, 0, 0);
        base = strobe_seen;
        drive(0, 0, 0, 0, 1, 0);
        wait_strobes(base + 2, 50);
        din = ~din;
        tick();
        wait_quiet(200);
        check("t3_strobe_count", strobe_seen - base, 8);
        check("t3_deferred", deferred, 1);
        check("t3_toggle_after_batch", last_tog_cyc, strobe_cyc_log[base+7] + 1);
        check("t3_toggle_forwarded", dout, din);

        // 4: overflow poisons the batch; the following batch is unaffected.
        for (int i = 0; i < 17; i++) drive(1, 1, i, 32'hBEEF_0000 + i, 0, 0);
        check("t4_overflow", overflow, 1);
        check("t4_pending_full", pending, FIFO_DEPTH);
        base = strobe_seen;
        drive(0, 0, 0, 0, 1, 0);
        wait_quiet(100);
        check("t4_batch_discarded", strobe_seen - base, 0);
        check("t4_pending_rewound", pending, 0);
        drive(1, 3, 9, 32'h0000_0999, 1, 0);
        wait_quiet(100);
        check("t4_next_batch", strobe_seen - base, 1);
        check("t4_overflow_sticky", overflow, 1);
        drive(0, 0, 0, 0, 0, 1);
        check("t4_overflow_cleared", overflow, 0);

        // 5: frame and commit in the same idle cycle; frame goes first.
        drive(1, 0, 2, 32'h0000_0222, 0, 0);
        drive(1, 2, 3, 32'h0000_0333, 0, 0);
        base = strobe_seen;
        din = ~din;
        drive(0, 0, 0, 0, 1, 0);
        check("t5_toggle_first", dout, din);
        check("t5_busy", busy, 1);
        wait_quiet(200);
        check("t5_strobe_count", strobe_seen - base, 2);

        // 5b: reset in the middle of a drain.
        for (int i = 0; i < 6; i++) drive(1, 2, i, 32'h5000 + i, 0, 0);
        base = strobe_seen;
        drive(0, 0, 0, 0, 1, 0);
        wait_strobes(base + 2, 50);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        unc_q.delete();
        drop_flag = 1'b0;
        check("t5_rst_strobes", {st_clip, st_off, st_ffb, st_gain}, 0);
        check("t5_rst_pending", pending, 0);
        wait_quiet(200);

        // 6: random traffic respecting the minimum frame period.
        begin
            int since = 0;
            int period = 60;
            for (int c = 0; c < 3000; c++) begin
                bit we, cm, clr;
                if (since >= period) begin
                    check("t6_toggle_forwarded", dout, din);
                    din = ~din;
                    since = 0;
                    period = $urandom_range(55, 90);
                end else begin
                    since++;
                end
                we  = ($urandom_range(0, 99) < 30) && (unc_q.size() + exp_q.size() < 14);
                cm  = $urandom_range(0, 99) < 8;
                clr = $urandom_range(0, 99) < 2;
                drive(we, $urandom_range(0, 3), $urandom_range(0, RESULT_COUNT - 1), $urandom, cm, clr);
            end
        end
        drive(0, 0, 0, 0, 1, 0);
        wait_quiet(500);
        check("t6_final_toggle", dout, din);
        check("t6_no_overflow", overflow, 0);
        check("t6_pending_empty", pending, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
